// File: rtl/captura_numero.sv
// Keypad entry capture: debounces scanner codes, accepts one event per press,
// and assembles up to three BCD digits into a binary number committed by '#'.
module captura_numero #(
    parameter int STABLE_CYC  = 10_000,
    parameter int RELEASE_CYC = 60_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  boton,
    output logic [3:0]  tecla,
    output logic        tecla_valida,
    output logic [11:0] digitos,
    output logic [1:0]  num_digitos,
    output logic [9:0]  numero,
    output logic        valido
);

    localparam int MAX_CYC = (RELEASE_CYC > STABLE_CYC) ? RELEASE_CYC : STABLE_CYC;
    localparam int CNT_W   = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(RELEASE_CYC - 1);
    localparam logic [3:0] NO_KEY = 4'b1111;
    localparam logic [3:0] K_STAR = 4'b1101;
    localparam logic [3:0] K_HASH = 4'b1110;

    typedef enum logic [1:0] {IDLE, CONFIRM, WAIT_REL} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       cand_q, cand_d;
    logic [3:0]       tecla_q, tecla_d;
    logic             tv_q, tv_d;
    logic [11:0]      dig_q, dig_d;
    logic [1:0]       num_q, num_d;
    logic [9:0]       acc_q, acc_d;
    logic [9:0]       numero_q, numero_d;
    logic             valido_q, valido_d;
    logic             accept;

    // At most two digits are held when a third is pushed, so acc*10+d <= 999.
    function automatic logic [9:0] acc_push(input logic [9:0] acc, input logic [3:0] d);
        return acc * 10'd10 + {6'd0, d};
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cand_d   = cand_q;
        tecla_d  = tecla_q;
        tv_d     = 1'b0;
        dig_d    = dig_q;
        num_d    = num_q;
        acc_d    = acc_q;
        numero_d = numero_q;
        valido_d = 1'b0;
        accept   = 1'b0;

        case (state_q)
            IDLE: begin
                if (boton != NO_KEY) begin
                    state_d = CONFIRM;
                    cand_d  = boton;
                    cnt_d   = CNT_W'(1);
                end
            end
            CONFIRM: begin
                if (boton == cand_q) begin
                    if (cnt_q == STB_LAST) begin
                        accept  = 1'b1;
                        state_d = WAIT_REL;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            WAIT_REL: begin
                // Scanner gaps between column hits show as no-key; only a long run counts as release.
                if (boton == NO_KEY) begin
                    if (cnt_q == REL_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (accept) begin
            tecla_d = cand_q;
            tv_d    = 1'b1;
            if (cand_q <= 4'd9) begin
                if (num_q != 2'd3) begin
                    dig_d = {dig_q[7:0], cand_q};
                    acc_d = acc_push(acc_q, cand_q);
                    num_d = num_q + 2'd1;
                end
            end else if (cand_q == K_HASH) begin
                if (num_q != 2'd0) begin
                    numero_d = acc_q;
                    valido_d = 1'b1;
                    dig_d    = '0;
                    num_d    = '0;
                    acc_d    = '0;
                end
            end else if (cand_q == K_STAR) begin
                dig_d = '0;
                num_d = '0;
                acc_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            cand_q   <= NO_KEY;
            tecla_q  <= NO_KEY;
            tv_q     <= 1'b0;
            dig_q    <= '0;
            num_q    <= '0;
            acc_q    <= '0;
            numero_q <= '0;
            valido_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cand_q   <= cand_d;
            tecla_q  <= tecla_d;
            tv_q     <= tv_d;
            dig_q    <= dig_d;
            num_q    <= num_d;
            acc_q    <= acc_d;
            numero_q <= numero_d;
            valido_q <= valido_d;
        end
    end

    assign tecla        = tecla_q;
    assign tecla_valida = tv_q;
    assign digitos      = dig_q;
    assign num_digitos  = num_q;
    assign numero       = numero_q;
    assign valido       = valido_q;

endmodule
